fetch_unit: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register. Feeds the opcode/funct/rt fields to the main decoder in ID.
- Owns the PC and issues requests on an addr_ok/data_ok instruction SRAM-like bus.
- Applies branch/jump redirects from ID while honouring the MIPS delay slot.
- Applies exception flushes and holds its output under pipeline stall.

---
 rtl/fetch_unit.sv | 126 ++++++++++++
 tb/tb_fetch_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage and IF/ID register on an addr_ok/data_ok SRAM-like bus.
// Define FETCH_ALIGN_CHECK_EN to add if_id_adel_o reporting of misaligned fetch addresses.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        inst_req_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_addr_ok_i,
    input  logic [31:0] inst_rdata_i,
    input  logic        inst_data_ok_i,
    output logic        if_id_valid_o,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_inst_o,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic        if_id_adel_o,
`endif
    output logic        if_busy_o
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, pc_n, tgt_q, tgt_d, hold_q, hold_d;
    logic [31:0] if_id_pc_q, if_id_pc_d, if_id_inst_q, if_id_inst_d;
    logic        pend_q, pend_d, req_q, req_d, if_id_valid_q, if_id_valid_d;
    logic        accepted, misalign, deliver, redirect;

`ifdef FETCH_ALIGN_CHECK_EN
    logic adel_q;
    assign misalign     = state_q == S_REQ && pc_q[1:0] != 2'b00;
    assign pc_d         = pc_n;
    assign if_id_adel_o = adel_q;
    always_ff @(posedge clk)
        adel_q <= (rst || flush_i) ? 1'b0 : stall_i ? adel_q : misalign;
`else
    assign misalign = 1'b0;
    assign pc_d     = pc_n & ~32'd3;
`endif

    assign accepted = req_q & inst_addr_ok_i;
    assign deliver  = !flush_i && !stall_i &&
                      ((state_q == S_WAIT && inst_data_ok_i) || state_q == S_HOLD || misalign);
    // A parked misaligned fetch waits for a flush and ignores redirects.
    assign redirect = redirect_valid_i && !misalign;
    assign req_d    = state_d == S_REQ && pc_d[1:0] == 2'b00;

    always_comb begin
        state_d       = state_q;
        pc_n          = pc_q;
        pend_d        = pend_q;
        tgt_d         = tgt_q;
        hold_d        = hold_q;
        if_id_valid_d = if_id_valid_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_inst_d  = if_id_inst_q;
        if (flush_i) begin
            // A request still in flight must have its data swallowed before refetching.
            state_d       = (((state_q == S_WAIT || state_q == S_DROP) && !inst_data_ok_i) ||
                             (state_q == S_REQ && accepted)) ? S_DROP : S_REQ;
            pc_n          = flush_pc_i;
            pend_d        = 1'b0;
            if_id_valid_d = 1'b0;
            if_id_inst_d  = 32'd0;
        end else begin
            case (state_q)
                S_REQ:   state_d = accepted ? S_WAIT : S_REQ;
                S_WAIT:  state_d = !inst_data_ok_i ? S_WAIT : stall_i ? S_HOLD : S_REQ;
                S_HOLD:  state_d = stall_i ? S_HOLD : S_REQ;
                default: state_d = inst_data_ok_i ? S_REQ : S_DROP;
            endcase
            if (state_q == S_WAIT && inst_data_ok_i)
                hold_d = inst_rdata_i;
            // Redirect coinciding with the delay-slot delivery lands on pc directly.
            if (deliver && !misalign) begin
                pc_n   = redirect ? redirect_pc_i : pend_q ? tgt_q : pc_q + 32'd4;
                pend_d = 1'b0;
            end else if (redirect) begin
                pend_d = 1'b1;
                tgt_d  = redirect_pc_i;
            end
            if (!stall_i) begin
                if_id_valid_d = deliver;
                if_id_pc_d    = deliver ? pc_q : if_id_pc_q;
                if_id_inst_d  = (!deliver || misalign) ? 32'd0 :
                                state_q == S_HOLD ? hold_q : inst_rdata_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            pend_q        <= 1'b0;
            tgt_q         <= 32'd0;
            hold_q        <= 32'd0;
            req_q         <= 1'b0;
            if_id_valid_q <= 1'b0;
            if_id_pc_q    <= 32'd0;
            if_id_inst_q  <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_q        <= pend_d;
            tgt_q         <= tgt_d;
            hold_q        <= hold_d;
            req_q         <= req_d;
            if_id_valid_q <= if_id_valid_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_inst_q  <= if_id_inst_d;
        end
    end

    assign inst_req_o    = req_q;
    assign inst_addr_o   = pc_q;
    assign if_id_valid_o = if_id_valid_q;
    assign if_id_pc_o    = if_id_pc_q;
    assign if_id_inst_o  = if_id_inst_q;
    assign if_busy_o     = !stall_i && !deliver;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random checks of fetch_unit against a program-order model
// with a single-outstanding memory responder whose words are a hash of the address.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst, stall, flush, rv, aok, dok, req, valid, busy;
    logic [31:0] fpc, rpc, rdata, addr, id_pc, id_inst;
    int          checks = 0, errors = 0, p_aok = 100, p_dok = 100, idle = 0;
    logic [31:0] exp_next, tgt, oaddr;
    bit          pend, in_ds, outst, live;
    logic [31:0] issued[$], delivered[$];

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush), .flush_pc_i(fpc),
        .redirect_valid_i(rv), .redirect_pc_i(rpc), .inst_req_o(req), .inst_addr_o(addr),
        .inst_addr_ok_i(aok), .inst_rdata_i(rdata), .inst_data_ok_i(dok),
        .if_id_valid_o(valid), .if_id_pc_o(id_pc), .if_id_inst_o(id_inst), .if_busy_o(busy)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive the responder, let the edge happen, then check against the model.
    task automatic step();
        logic        req_b, val_b, busy_b;
        logic [31:0] addr_b, pc_b, inst_b;
        aok   = !rst && req && !outst && ($urandom_range(99) < p_aok);
        dok   = outst && ($urandom_range(99) < p_dok);
        rdata = dok ? mem(oaddr) : $urandom;
        #1;
        req_b = req; addr_b = addr; val_b = valid; pc_b = id_pc; inst_b = id_inst; busy_b = busy;
        @(negedge clk);
        if (dok && live && !stall && !flush && !rst)
            chk("latency", valid, 1);
        if (dok) outst = 0;
        if (aok) begin outst = 1; oaddr = addr_b; issued.push_back(addr_b); end
        live = (rst || flush) ? 0 : aok ? 1 : dok ? 0 : live;
        if (rst) begin
            chk("rst_req", req, 0);
            chk("rst_addr", addr, RESET_PC);
            chk("rst_valid", valid, 0);
            chk("rst_pc", id_pc, 0);
            chk("rst_inst", id_inst, 0);
            exp_next = RESET_PC; pend = 0; in_ds = 0; idle = 0;
        end else begin
            chk("busy", busy_b, !stall && !valid);
            if (req_b && !aok && !flush) begin
                chk("req_hold", req, 1);
                chk("addr_hold", addr, addr_b);
            end
            if (flush) begin
                chk("flush_valid", valid, 0);
                chk("flush_inst", id_inst, 0);
                exp_next = fpc; pend = 0; in_ds = 0;
            end else if (stall) begin
                chk("hold_valid", valid, val_b);
                chk("hold_pc", id_pc, pc_b);
                chk("hold_inst", id_inst, inst_b);
            end else begin
                if (rv) begin pend = 1; tgt = rpc; end
                if (valid) begin
                    chk("pc", id_pc, exp_next);
                    chk("inst", id_inst, mem(exp_next));
                    delivered.push_back(id_pc);
                    in_ds = pend;
                    exp_next = pend ? tgt : exp_next + 32'd4;
                    pend = 0;
                    idle = 0;
                end else chk("bubble_inst", id_inst, 0);
            end
            idle++;
            if (idle > 200) begin
                chk("watchdog", idle, 0);
                idle = 0;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1; stall = 0; flush = 0; rv = 0;
        step(); step();
        rst = 0;
        issued.delete(); delivered.delete();
    endtask

    initial begin
        stall = 0; flush = 0; rv = 0; fpc = 0; rpc = 0; aok = 0; dok = 0; rdata = 0;
        outst = 0; live = 0; pend = 0; in_ds = 0; exp_next = RESET_PC; tgt = 0; oaddr = 0;
        do_reset();

        // Straight-line fetch with single-cycle responses
        repeat (12) step();
        chk("iss0", issued[0], 32'hBFC0_0000);
        chk("iss1", issued[1], 32'hBFC0_0004);
        chk("iss2", issued[2], 32'hBFC0_0008);
        chk("dlv0", delivered[0], 32'hBFC0_0000);
        chk("dlv2", delivered[2], 32'hBFC0_0008);

        // Redirect while ID holds the branch: delay slot still fetched
        do_reset();
        for (int g = 0; g < 30; g++) begin
            rv = valid && id_pc == RESET_PC && !pend && !in_ds && delivered.size() == 1;
            rpc = 32'h8000_0100;
            step();
        end
        rv = 0;
        chk("redir_iss1", issued[1], 32'hBFC0_0004);
        chk("redir_iss2", issued[2], 32'h8000_0100);
        chk("redir_dlv1", delivered[1], 32'hBFC0_0004);
        chk("redir_dlv2", delivered[2], 32'h8000_0100);

        // Stall across the data return of BFC00008
        do_reset();
        for (int g = 0; g < 30 && issued.size() < 3; g++) step();
        chk("stall_reach", issued.size(), 3);
        stall = 1;
        repeat (4) begin step(); chk("stall_noreq", req, 0); end
        stall = 0;
        step();
        chk("unstall_pc", id_pc, 32'hBFC0_0008);
        chk("unstall_inst", id_inst, mem(32'hBFC0_0008));
        chk("unstall_req", req, 1);
        chk("unstall_addr", addr, 32'hBFC0_000C);

        // Flush while a request is outstanding: its data is dropped
        do_reset();
        p_dok = 0;
        for (int g = 0; g < 10 && !outst; g++) step();
        chk("flush_reach", outst, 1);
        flush = 1; fpc = 32'hBFC0_0380;
        step();
        flush = 0; p_dok = 100;
        repeat (10) step();
        chk("flush_iss", issued[1], 32'hBFC0_0380);
        chk("flush_dlv0", delivered[0], 32'hBFC0_0380);

        // Flush and redirect together: flush wins
        do_reset();
        for (int g = 0; g < 10 && !valid; g++) step();
        chk("fr_reach", valid, 1);
        delivered.delete();
        flush = 1; fpc = 32'hBFC0_0380; rv = 1; rpc = 32'h8000_0100;
        step();
        flush = 0; rv = 0;
        repeat (12) step();
        chk("fr_dlv0", delivered[0], 32'hBFC0_0380);
        chk("fr_dlv1", delivered[1], 32'hBFC0_0384);

        // Redirect to the top of the address space: pc wraps to 0
        do_reset();
        for (int g = 0; g < 10 && !valid; g++) step();
        delivered.delete();
        rv = 1; rpc = 32'hFFFF_FFFC;
        step();
        rv = 0;
        repeat (12) step();
        chk("wrap_dlv0", delivered[0], 32'hBFC0_0004);
        chk("wrap_dlv1", delivered[1], 32'hFFFF_FFFC);
        chk("wrap_dlv2", delivered[2], 32'h0000_0000);

        // Random traffic, stalls, flushes, redirects and resets
        p_aok = 60; p_dok = 50;
        for (int c = 0; c < 3000; c++) begin
            rst   = $urandom_range(299) == 0;
            stall = !rst && $urandom_range(99) < 25;
            flush = !rst && $urandom_range(99) < 3;
            fpc   = $urandom & 32'hFFFF_FFFC;
            rv    = !rst && !stall && valid && !pend && !in_ds && $urandom_range(99) < 25;
            rpc   = ($urandom_range(3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
